// File: rtl/key_event_ctrl.sv
// Classifies debounced key presses as SHORT/LONG/REPEAT and queues them through a
// round-robin arbiter into a 4-entry event FIFO drained over valid/ready.
module key_event_ctrl #(
  parameter int KEYS          = 4,
  parameter int LONG_CYCLES   = 27_000_000,
  parameter int REPEAT_CYCLES = 5_400_000,
  parameter bit REPEAT_EN     = 1'b1
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [KEYS-1:0] KEY_FLAG,
  input  logic [KEYS-1:0] KEY_STATE,
  input  logic            EVT_READY,
  input  logic            OVF_CLR,
  output logic            EVT_VALID,
  output logic [2:0]      EVT_KEY,
  output logic [1:0]      EVT_TYPE,
  output logic [KEYS-1:0] KEY_HELD,
  output logic            OVERFLOW
);

  localparam int IW = (KEYS > 1) ? $clog2(KEYS) : 1;

  localparam logic [1:0] EV_SHORT  = 2'b01;
  localparam logic [1:0] EV_LONG   = 2'b10;
  localparam logic [1:0] EV_REPEAT = 2'b11;

  localparam logic [24:0] LONG_LAST = 25'(LONG_CYCLES - 1);
  localparam logic [24:0] REP_LAST  = 25'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HELD = 2'd1,
    ST_LONG = 2'd2
  } key_state_e;

  key_state_e      state_q   [KEYS];
  key_state_e      state_d   [KEYS];
  logic [24:0]     cnt_q     [KEYS];
  logic [24:0]     cnt_d     [KEYS];
  logic [KEYS-1:0] post;
  logic [1:0]      post_type [KEYS];
  logic [KEYS-1:0] press;
  logic [KEYS-1:0] release_s;

  logic [KEYS-1:0] slot_valid_q;
  logic [1:0]      slot_type_q [KEYS];

  logic [IW-1:0]   last_q;
  logic [IW-1:0]   grant_idx;
  logic            grant_any;
  logic [KEYS-1:0] grant;
  logic [3:0]      idx;
  logic            ovf_set;

  logic [2:0]      fifo_key  [4];
  logic [1:0]      fifo_type [4];
  logic [1:0]      wr_ptr;
  logic [1:0]      rd_ptr;
  logic [2:0]      fifo_cnt_q;
  logic            push;
  logic            pop;

  assign press     = KEY_FLAG & ~KEY_STATE;
  assign release_s = KEY_FLAG & KEY_STATE;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < KEYS; i++) begin
        state_q[i] <= ST_IDLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < KEYS; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  // Release beats the LONG threshold when both land on the same edge.
  always_comb begin
    for (int i = 0; i < KEYS; i++) begin
      state_d[i]   = state_q[i];
      cnt_d[i]     = cnt_q[i];
      post[i]      = 1'b0;
      post_type[i] = EV_SHORT;
      case (state_q[i])
        ST_IDLE: begin
          if (press[i]) begin
            state_d[i] = ST_HELD;
            cnt_d[i]   = '0;
          end
        end
        ST_HELD: begin
          if (release_s[i]) begin
            state_d[i]   = ST_IDLE;
            cnt_d[i]     = '0;
            post[i]      = 1'b1;
            post_type[i] = EV_SHORT;
          end else if (cnt_q[i] == LONG_LAST) begin
            state_d[i]   = ST_LONG;
            cnt_d[i]     = '0;
            post[i]      = 1'b1;
            post_type[i] = EV_LONG;
          end else begin
            cnt_d[i] = cnt_q[i] + 25'd1;
          end
        end
        ST_LONG: begin
          if (release_s[i]) begin
            state_d[i] = ST_IDLE;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == REP_LAST) begin
            cnt_d[i]     = '0;
            post[i]      = REPEAT_EN;
            post_type[i] = EV_REPEAT;
          end else begin
            cnt_d[i] = cnt_q[i] + 25'd1;
          end
        end
        default: begin
          state_d[i] = ST_IDLE;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < KEYS; i++) begin
      KEY_HELD[i] = (state_q[i] != ST_IDLE);
    end
  end

  // Round-robin search begins one past the most recently granted key.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = last_q;
    idx       = '0;
    if (fifo_cnt_q != 3'd4) begin
      for (int off = 1; off <= KEYS; off++) begin
        idx = 4'(last_q) + 4'(off);
        if (idx >= 4'(KEYS)) begin
          idx = idx - 4'(KEYS);
        end
        if (!grant_any && slot_valid_q[idx[IW-1:0]]) begin
          grant_any = 1'b1;
          grant_idx = idx[IW-1:0];
        end
      end
    end
    grant = grant_any ? (KEYS'(1) << grant_idx) : '0;
  end

  assign ovf_set = |(post & slot_valid_q & ~grant);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      slot_valid_q <= '0;
      for (int i = 0; i < KEYS; i++) begin
        slot_type_q[i] <= 2'b00;
      end
      last_q   <= IW'(KEYS - 1);
      OVERFLOW <= 1'b0;
    end else begin
      for (int i = 0; i < KEYS; i++) begin
        if (post[i]) begin
          slot_valid_q[i] <= 1'b1;
          slot_type_q[i]  <= post_type[i];
        end else if (grant[i]) begin
          slot_valid_q[i] <= 1'b0;
        end
      end
      if (grant_any) begin
        last_q <= grant_idx;
      end
      if (ovf_set) begin
        OVERFLOW <= 1'b1;
      end else if (OVF_CLR) begin
        OVERFLOW <= 1'b0;
      end
    end
  end

  assign push = grant_any;
  assign pop  = EVT_VALID & EVT_READY;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < 4; i++) begin
        fifo_key[i]  <= 3'd0;
        fifo_type[i] <= 2'b00;
      end
      wr_ptr     <= 2'd0;
      rd_ptr     <= 2'd0;
      fifo_cnt_q <= 3'd0;
    end else begin
      if (push) begin
        fifo_key[wr_ptr]  <= 3'(grant_idx);
        fifo_type[wr_ptr] <= slot_type_q[grant_idx];
        wr_ptr            <= wr_ptr + 2'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 2'd1;
      end
      fifo_cnt_q <= fifo_cnt_q + {2'b00, push} - {2'b00, pop};
    end
  end

  assign EVT_VALID = (fifo_cnt_q != 3'd0);
  assign EVT_KEY   = EVT_VALID ? fifo_key[rd_ptr]  : 3'd0;
  assign EVT_TYPE  = EVT_VALID ? fifo_type[rd_ptr] : 2'b00;

endmodule

// File: tb/tb_key_event_ctrl.sv
// Bench for key_event_ctrl: two instances (REPEAT_EN 1 and 0) checked against a
// timestamp-based key model whose expected-event queues also act as the FIFO model.
module tb_key_event_ctrl;

  localparam int KEYS = 8;
  localparam int LONG = 10;
  localparam int REP  = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [KEYS-1:0] key_flag  = '0;
  logic [KEYS-1:0] key_state = '1;
  logic            evt_ready = 1'b1;
  logic            ovf_clr   = 1'b0;

  logic            evt_valid [2];
  logic [2:0]      evt_key   [2];
  logic [1:0]      evt_type  [2];
  logic [KEYS-1:0] key_held  [2];
  logic            overflow  [2];

  int errors = 0;
  int checks = 0;

  logic [4:0]      exp0 [$];
  logic [4:0]      exp1 [$];
  logic [KEYS-1:0] m_held [2];
  logic [KEYS-1:0] m_pv   [2];
  logic [1:0]      m_pt   [2][KEYS];
  int              m_t0   [2][KEYS];
  int              m_last [2];
  logic            m_ovf  [2];
  int              m_now = 0;

  always #5 clk = ~clk;

  key_event_ctrl #(.KEYS(KEYS), .LONG_CYCLES(LONG), .REPEAT_CYCLES(REP), .REPEAT_EN(1'b1)) dut0 (
    .CLK(clk), .RST(rst), .KEY_FLAG(key_flag), .KEY_STATE(key_state),
    .EVT_READY(evt_ready), .OVF_CLR(ovf_clr), .EVT_VALID(evt_valid[0]),
    .EVT_KEY(evt_key[0]), .EVT_TYPE(evt_type[0]), .KEY_HELD(key_held[0]),
    .OVERFLOW(overflow[0])
  );

  key_event_ctrl #(.KEYS(KEYS), .LONG_CYCLES(LONG), .REPEAT_CYCLES(REP), .REPEAT_EN(1'b0)) dut1 (
    .CLK(clk), .RST(rst), .KEY_FLAG(key_flag), .KEY_STATE(key_state),
    .EVT_READY(evt_ready), .OVF_CLR(ovf_clr), .EVT_VALID(evt_valid[1]),
    .EVT_KEY(evt_key[1]), .EVT_TYPE(evt_type[1]), .KEY_HELD(key_held[1]),
    .OVERFLOW(overflow[1])
  );

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
    end
  endtask

  function automatic int qsize(input int d);
    return (d == 0) ? exp0.size() : exp1.size();
  endfunction

  function automatic logic [4:0] qfront(input int d);
    return (d == 0) ? exp0[0] : exp1[0];
  endfunction

  task automatic qpop(input int d);
    if (d == 0) void'(exp0.pop_front());
    else        void'(exp1.pop_front());
  endtask

  task automatic qpush(input int d, input logic [4:0] v);
    if (d == 0) exp0.push_back(v);
    else        exp1.push_back(v);
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_held[d] = '0;
      m_pv[d]   = '0;
      m_ovf[d]  = 1'b0;
      m_last[d] = KEYS - 1;
      for (int k = 0; k < KEYS; k++) begin
        m_pt[d][k] = 2'b00;
        m_t0[d][k] = 0;
      end
    end
    exp0.delete();
    exp1.delete();
  endtask

  // One clock edge of behaviour: hold time is measured as edges elapsed since the press.
  task automatic model_step(input int d, input logic [KEYS-1:0] f, input logic [KEYS-1:0] s,
                            input logic rdy, input logic clr, input logic rep_en);
    logic [KEYS-1:0] pr;
    logic [KEYS-1:0] rl;
    int sz, gk, el, k;
    logic ovs, post;
    logic [1:0] pt;
    pr = f & ~s;
    rl = f & s;
    sz = qsize(d);
    if (sz > 0 && rdy) qpop(d);
    gk = -1;
    if (sz < 4) begin
      for (int o = 1; o <= KEYS; o++) begin
        k = (m_last[d] + o) % KEYS;
        if (gk < 0 && m_pv[d][k]) gk = k;
      end
    end
    if (gk >= 0) begin
      qpush(d, {3'(gk), m_pt[d][gk]});
      m_pv[d][gk] = 1'b0;
      m_last[d]   = gk;
    end
    ovs = 1'b0;
    for (int i = 0; i < KEYS; i++) begin
      post = 1'b0;
      pt   = 2'b00;
      if (!m_held[d][i]) begin
        if (pr[i]) begin
          m_held[d][i] = 1'b1;
          m_t0[d][i]   = m_now;
        end
      end else begin
        el = m_now - m_t0[d][i];
        if (rl[i]) begin
          m_held[d][i] = 1'b0;
          if (el <= LONG) begin post = 1'b1; pt = 2'b01; end
        end else if (el == LONG) begin
          post = 1'b1; pt = 2'b10;
        end else if (el > LONG && ((el - LONG) % REP) == 0 && rep_en) begin
          post = 1'b1; pt = 2'b11;
        end
      end
      if (post) begin
        if (m_pv[d][i]) ovs = 1'b1;
        m_pv[d][i] = 1'b1;
        m_pt[d][i] = pt;
      end
    end
    if (ovs) m_ovf[d] = 1'b1;
    else if (clr) m_ovf[d] = 1'b0;
  endtask

  task automatic compare(input int d);
    logic [4:0] fr;
    checkOutput($sformatf("dut%0d.valid", d), int'(evt_valid[d]), int'(qsize(d) > 0));
    if (qsize(d) > 0) begin
      fr = qfront(d);
      checkOutput($sformatf("dut%0d.key", d), int'(evt_key[d]), int'(fr[4:2]));
      checkOutput($sformatf("dut%0d.type", d), int'(evt_type[d]), int'(fr[1:0]));
    end
    checkOutput($sformatf("dut%0d.held", d), int'(key_held[d]), int'(m_held[d]));
    checkOutput($sformatf("dut%0d.overflow", d), int'(overflow[d]), int'(m_ovf[d]));
  endtask

  // Monitor: inputs change 2 time units after each edge, so at +1 they still hold what was sampled.
  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        model_reset();
      end else begin
        model_step(0, key_flag, key_state, evt_ready, ovf_clr, 1'b1);
        model_step(1, key_flag, key_state, evt_ready, ovf_clr, 1'b0);
      end
      m_now++;
      compare(0);
      compare(1);
    end
  end

  task automatic applyStimulus(input logic [KEYS-1:0] pr, input logic [KEYS-1:0] rl,
                               input logic rdy, input logic clr);
    key_flag  = pr | rl;
    key_state = (key_state | rl) & ~pr;
    evt_ready = rdy;
    ovf_clr   = clr;
    @(posedge clk);
    #2;
    key_flag = '0;
    ovf_clr  = 1'b0;
  endtask

  task automatic idle(input int n, input logic rdy);
    evt_ready = rdy;
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    #2_000_000;
    errors++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [KEYS-1:0] rp, rr;
    int guard;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    for (int d = 0; d < 2; d++) begin
      checkOutput($sformatf("reset.key%0d", d), int'(evt_key[d]), 0);
      checkOutput($sformatf("reset.type%0d", d), int'(evt_type[d]), 0);
    end
    rst = 1'b0;
    idle(2, 1'b1);

    // Short press on key 1
    applyStimulus(8'h02, 8'h00, 1'b1, 1'b0);
    idle(4, 1'b1);
    applyStimulus(8'h00, 8'h02, 1'b1, 1'b0);
    idle(6, 1'b1);

    // Key 2 held 20 cycles: LONG then REPEATs (dut1 LONG only)
    applyStimulus(8'h04, 8'h00, 1'b1, 1'b0);
    idle(19, 1'b1);
    applyStimulus(8'h00, 8'h04, 1'b1, 1'b0);
    idle(8, 1'b1);

    // Key 0 released exactly at the LONG threshold edge
    applyStimulus(8'h01, 8'h00, 1'b1, 1'b0);
    idle(9, 1'b1);
    applyStimulus(8'h00, 8'h01, 1'b1, 1'b0);
    idle(6, 1'b1);

    // Simultaneous bursts on keys 0..3, twice
    repeat (2) begin
      applyStimulus(8'h0F, 8'h00, 1'b1, 1'b0);
      idle(2, 1'b1);
      applyStimulus(8'h00, 8'h0F, 1'b1, 1'b0);
      idle(8, 1'b1);
    end

    // FIFO full with consumer stalled, then overwrite of pending slots
    applyStimulus(8'h3F, 8'h00, 1'b0, 1'b0);
    idle(2, 1'b0);
    applyStimulus(8'h00, 8'h3F, 1'b0, 1'b0);
    idle(8, 1'b0);
    applyStimulus(8'h3F, 8'h00, 1'b0, 1'b0);
    idle(1, 1'b0);
    applyStimulus(8'h00, 8'h3F, 1'b0, 1'b0);
    idle(4, 1'b0);
    idle(12, 1'b1);
    applyStimulus(8'h00, 8'h00, 1'b1, 1'b1);
    idle(3, 1'b1);

    // Reset with events queued and key 1 in LONG
    applyStimulus(8'h02, 8'h00, 1'b1, 1'b0);
    idle(12, 1'b1);
    applyStimulus(8'h38, 8'h00, 1'b0, 1'b0);
    idle(1, 1'b0);
    applyStimulus(8'h00, 8'h38, 1'b0, 1'b0);
    idle(6, 1'b0);
    rst = 1'b1;
    #1;
    checkOutput("async_rst.valid", int'(evt_valid[0]), 0);
    checkOutput("async_rst.held", int'(key_held[0]), 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    applyStimulus(8'h00, 8'h02, 1'b1, 1'b0);
    idle(5, 1'b1);

    // Randomized traffic
    for (int c = 0; c < 600; c++) begin
      rp = '0;
      rr = '0;
      for (int k = 0; k < KEYS; k++) begin
        if ($urandom_range(0, 15) == 0) begin
          if ($urandom_range(0, 1) == 1) rp[k] = 1'b1;
          else                           rr[k] = 1'b1;
        end
      end
      applyStimulus(rp, rr, ($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0));
    end

    // Release everything and drain
    applyStimulus(8'h00, 8'hFF, 1'b1, 1'b0);
    guard = 0;
    while ((exp0.size() > 0 || exp1.size() > 0) && guard < 60) begin
      idle(1, 1'b1);
      guard++;
    end
    idle(2, 1'b1);
    checkOutput("drain.valid0", int'(evt_valid[0]), 0);
    checkOutput("drain.valid1", int'(evt_valid[1]), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/key_event_ctrl.md
# key_event_ctrl

Key-event scheduler between the per-key debouncers and the clock's setting/mode logic. It consumes each debouncer's one-cycle `KEY_FLAG` and level `KEY_STATE` and classifies every press as SHORT, LONG or auto-REPEAT. It arbitrates simultaneous events from all keys round-robin into a 4-entry event FIFO. Downstream logic drains that FIFO one event at a time over a valid/ready handshake.

## Interface
- `KEYS`, 4: number of keys; 2..8.
- `LONG_CYCLES`, 27_000_000: hold cycles before a LONG event (1 s at 27 MHz); ≥2.
- `REPEAT_CYCLES`, 5_400_000: cycles between REPEAT events while held past LONG; ≥2.
- `REPEAT_EN`, 1: 0 suppresses REPEAT events.
- `CLK  in  1`: system clock. One clock domain, all logic on the rising edge.
- `RST  in  1`: reset, asynchronous, active-high.
- `KEY_FLAG  in  KEYS`: per-key one-cycle debounced edge strobe.
- `KEY_STATE  in  KEYS`: per-key debounced level, 0 = pressed. Valid whenever `KEY_FLAG` is high.
- `EVT_READY  in  1`: consumer accepts the head event.
- `OVF_CLR  in  1`: clears `OVERFLOW`.
- `EVT_VALID  out  1`: FIFO non-empty.
- `EVT_KEY  out  3`: key index of the head event.
- `EVT_TYPE  out  2`: head event type. 01 SHORT, 10 LONG, 11 REPEAT; 00 never valid.
- `KEY_HELD  out  KEYS`: per-key bit, high while that key's FSM is not IDLE.
- `OVERFLOW  out  1`: sticky; an event was lost.

## Operation
- Per-key decode: press = `KEY_FLAG[i] & ~KEY_STATE[i]`; release = `KEY_FLAG[i] & KEY_STATE[i]`.
- Per-key FSM with a 25-bit hold counter; states IDLE, HELD, LONG.
  - IDLE: on press, go to HELD and clear the counter. On release, stay IDLE and post nothing.
  - HELD: counter increments every cycle.
    - On release: post SHORT, go to IDLE.
    - Else when counter == LONG_CYCLES-1: post LONG, go to LONG, clear the counter.
    - Release in the same cycle as the threshold: release wins, post SHORT only.
  - LONG: counter increments every cycle.
    - On release: go to IDLE, post nothing.
    - Else when counter == REPEAT_CYCLES-1: clear the counter; post REPEAT if `REPEAT_EN`=1.
  - A press seen in HELD or LONG is ignored.
- Pending slot, one per key (valid bit + type):
  - A post loads the slot.
  - Posting while the slot is already valid and not granted that cycle overwrites it with the newer type and sets `OVERFLOW`.
  - Posting in the same cycle the slot is granted: the grant takes the old contents, the slot loads the new type and stays valid, no overflow.
- Arbiter:
  - Grants at most one pending key per cycle, and only when the FIFO count < 4. The count is the registered value; a same-cycle pop does not free space.
  - Search order is round-robin starting at (last granted index + 1) mod KEYS. After reset, last granted = KEYS-1, so key 0 has first priority.
  - A grant pushes {key index, type} into the FIFO and clears that slot's valid bit.
- FIFO:
  - Depth 4, first-in first-out.
  - Head drives `EVT_KEY`/`EVT_TYPE`.
  - Pop occurs when `EVT_VALID & EVT_READY`.
  - Push and pop in the same cycle are both honoured; the count is unchanged.
  - The FIFO never overflows; loss happens only by pending-slot overwrite.
- `OVERFLOW`: set by an overwrite, cleared by `OVF_CLR`. Set wins if both happen in the same cycle.
- `KEY_HELD[i]` = FSM state ≠ IDLE, registered.

## Timing
- Reset values:
  - Outputs: `EVT_VALID`=0, `EVT_KEY`=0, `EVT_TYPE`=00, `KEY_HELD`=0, `OVERFLOW`=0.
  - Internal: all FSMs IDLE, counters 0, slots empty, FIFO empty.
- Assertion of `RST` mid-operation immediately discards queued and pending events and hold progress.
- Event latency, uncontended and FIFO empty: strobe in cycle 0 → slot valid in cycle 1 → push at the end of cycle 1 → `EVT_VALID` high in cycle 2.
- LONG posts on the edge where counter = LONG_CYCLES-1, i.e. LONG_CYCLES cycles after the press-strobe edge. REPEAT posts every REPEAT_CYCLES cycles after that.
- While `EVT_VALID`=1 and `EVT_READY`=0, `EVT_KEY`/`EVT_TYPE` hold stable.
- Sustained throughput: one event per cycle.

## Test plan
Benches use `LONG_CYCLES`=10 and `REPEAT_CYCLES`=4.
- Key 1 press, release 5 cycles later, `EVT_READY`=1 → single event KEY=1, TYPE=01, `EVT_VALID` rising 2 cycles after the release strobe. `KEY_HELD[1]` is high from the cycle after the press strobe until the cycle after the release strobe.
- Key 2 held for 20 cycles → LONG at press+10, REPEAT at press+14 and press+18, no event on release. With `REPEAT_EN`=0 → only the LONG.
- Key 0 release strobe exactly at counter 9 → only SHORT, no LONG.
- Keys 0..3 press/release together, `EVT_READY`=1 → SHORTs emitted in key order 0,1,2,3 on consecutive cycles. Repeating the burst → order 0,1,2,3 again (last grant was 3).
- `EVT_READY`=0 with 6 SHORT events from distinct keys → FIFO fills at 4 and `EVT_VALID`/head stay stable. A second SHORT on a still-pending key → `OVERFLOW`=1. Then `EVT_READY`=1 → events drain in order, and `OVF_CLR` → `OVERFLOW`=0.
- `RST` asserted with 3 queued events and key 1 in LONG → next cycle `EVT_VALID`=0 and `KEY_HELD`=0. After deassert, a release strobe on key 1 produces no event.
